// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetches a 16-bit instruction as two memory bytes and drives the IR load controls.
// Define FETCH_TIMEOUT_EN to add a MemAck wait counter and an ERR abort state.
module instruction_fetch_unit #(
  parameter logic [15:0] RESET_PC       = 16'h0000,
  parameter int          TIMEOUT_CYCLES = 15
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic        PCLoad,
  input  logic [15:0] PCIn,
  output logic        MemReq,
  output logic [15:0] MemAddr,
  input  logic        MemAck,
  input  logic [7:0]  MemData,
  output logic        IR_E,
  output logic [2:0]  IR_FunSel,
  output logic [15:0] IR_I,
  output logic [15:0] PC,
  output logic        Busy,
  output logic        Done,
  output logic        Error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ_LO = 3'd1,
    S_REQ_HI = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  state_t      state, state_nx;
  logic [15:0] pc_q, pc_nx;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must lie in 1..255");
  end

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt;
  logic       timeout;

  // Counts only unacknowledged REQ cycles; any state change or ack restarts the wait.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)
      wait_cnt <= '0;
    else if (state_nx != state || MemAck)
      wait_cnt <= '0;
    else if (state == S_REQ_LO || state == S_REQ_HI)
      wait_cnt <= wait_cnt + 8'd1;
  end

  assign timeout = !MemAck && (wait_cnt == WAIT_LAST);
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= S_IDLE;
      pc_q  <= RESET_PC;
    end else begin
      state <= state_nx;
      pc_q  <= pc_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc_q;
    case (state)
      S_IDLE: begin
        if (PCLoad) pc_nx = PCIn;
        if (Start)  state_nx = S_REQ_LO;
      end
      S_REQ_LO: begin
        if (MemAck) begin
          pc_nx    = pc_q + 16'd1;
          state_nx = S_REQ_HI;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (timeout) state_nx = S_ERR;
`endif
      end
      S_REQ_HI: begin
        if (MemAck) begin
          pc_nx    = pc_q + 16'd1;
          state_nx = S_DONE;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (timeout) state_nx = S_ERR;
`endif
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // IR controls are combinational so the IR captures on the same edge that advances the FSM.
  always_comb begin
    MemReq    = 1'b0;
    IR_E      = 1'b0;
    IR_FunSel = 3'b000;
    Done      = 1'b0;
    Error     = 1'b0;
    Busy      = (state != S_IDLE);
    case (state)
      S_REQ_LO: begin
        MemReq = 1'b1;
        if (MemAck) begin
          IR_E      = 1'b1;
          IR_FunSel = 3'b100;
        end
      end
      S_REQ_HI: begin
        MemReq = 1'b1;
        if (MemAck) begin
          IR_E      = 1'b1;
          IR_FunSel = 3'b110;
        end
      end
      S_DONE:  Done = 1'b1;
`ifdef FETCH_TIMEOUT_EN
      S_ERR:   Error = 1'b1;
`endif
      default: ;
    endcase
  end

  assign MemAddr = pc_q;
  assign PC      = pc_q;
  assign IR_I    = {8'h00, MemData};

endmodule
